// File: rtl/raster_tri_if.sv
// Triangle handshake, frame control and rasterizer-side bus for raster_tri_scheduler.
// slave is the scheduler's view; master is the view of the vertex stage, sequencer and rasterizer together.
interface raster_tri_if #(
  parameter int CNT_W = 16
);
  logic [359:0]     tri_in;
  logic             tri_valid;
  logic             tri_ready;
  logic             frame_start;
  logic             frame_end;
  logic [25:0]      fb_base;
  logic [359:0]     rast_tri;
  logic [25:0]      rast_addr;
  logic             rast_valid;
  logic             rast_last;
  logic             rast_done;
  logic             frame_done;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] culled_cnt;

  modport slave (
    input  tri_in, tri_valid, frame_start, frame_end, fb_base, rast_done,
    output tri_ready, rast_tri, rast_addr, rast_valid, rast_last,
           frame_done, busy, timeout_err, issued_cnt, culled_cnt
  );

  modport master (
    output tri_in, tri_valid, frame_start, frame_end, fb_base, rast_done,
    input  tri_ready, rast_tri, rast_addr, rast_valid, rast_last,
           frame_done, busy, timeout_err, issued_cnt, culled_cnt
  );
endinterface

// File: rtl/raster_tri_scheduler.sv
// Queues transformed triangles and feeds them one at a time to the rasterizer,
// culling axis-degenerate triangles and aborting hung ones with a watchdog.
//
// state | meaning
// IDLE  | no frame open; waiting for frame_start
// FETCH | pop next triangle (cull or launch), or finish once frame_end seen and queue empty
// RUN   | triangle presented to rasterizer; watchdog running
// DONE  | one-cycle frame_done pulse
module raster_tri_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 640*480,
  parameter int CNT_W   = 16
) (
  input logic        clock,
  input logic        reset,
  raster_tri_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  state_t            state, state_n;
  logic [359:0]      mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [359:0]      rast_tri_q;
  logic [25:0]       rast_addr_q;
  logic [CNT_W-1:0]  issued_q, culled_q;
  logic              timeout_q;
  logic              end_seen;
  logic [WW-1:0]     wdog;

  logic              full, empty, push, pop, degen;
  logic              start_frame, cull, launch, finish_ok, abort;
  logic [359:0]      head;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.tri_valid && !full;
  assign head  = mem[rd_ptr];

  // x fields at [359:328],[263:232],[167:136]; y fields at [327:296],[231:200],[135:104]
  assign degen = ((head[359:328] == head[263:232]) && (head[263:232] == head[167:136])) ||
                 ((head[327:296] == head[231:200]) && (head[231:200] == head[135:104]));

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    start_frame = 1'b0;
    cull        = 1'b0;
    launch      = 1'b0;
    finish_ok   = 1'b0;
    abort       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.frame_start) begin
          start_frame = 1'b1;
          state_n     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!empty) begin
          pop = 1'b1;
          if (degen) begin
            cull = 1'b1;
          end else begin
            launch  = 1'b1;
            state_n = S_RUN;
          end
        end else if (end_seen) begin
          state_n = S_DONE;
        end
      end
      S_RUN: begin
        // a completion arriving on the expiry cycle still counts as done
        if (bus.rast_done) begin
          finish_ok = 1'b1;
          state_n   = S_FETCH;
        end else if (wdog == '0) begin
          abort   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rast_tri_q  <= '0;
      rast_addr_q <= '0;
      issued_q    <= '0;
      culled_q    <= '0;
      timeout_q   <= 1'b0;
      end_seen    <= 1'b0;
      wdog        <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (start_frame) begin
        rast_addr_q <= bus.fb_base;
        issued_q    <= '0;
        culled_q    <= '0;
        timeout_q   <= 1'b0;
      end
      if (pop) rast_tri_q <= head;

      // watchdog counts down from TIMEOUT-1; expiry on terminal count zero
      if (launch)                           wdog <= WW'(TIMEOUT - 1);
      else if (state == S_RUN && wdog != '0) wdog <= wdog - 1'b1;

      if (cull && culled_q != '1)      culled_q <= culled_q + 1'b1;
      if (finish_ok && issued_q != '1) issued_q <= issued_q + 1'b1;
      if (abort) timeout_q <= 1'b1;

      if (state == S_DONE || start_frame)             end_seen <= 1'b0;
      else if (bus.frame_end && state != S_IDLE)      end_seen <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.tri_in;
  end

  assign bus.tri_ready   = !full;
  assign bus.rast_tri    = rast_tri_q;
  assign bus.rast_addr   = rast_addr_q;
  assign bus.rast_valid  = (state == S_RUN);
  assign bus.rast_last   = (state == S_RUN) && end_seen && empty;
  assign bus.frame_done  = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = timeout_q;
  assign bus.issued_cnt  = issued_q;
  assign bus.culled_cnt  = culled_q;

endmodule
